// File: rtl/dbg_tx_pkg.sv
// rtl/dbg_tx_pkg.sv - shared types and constants for the debug serial transmitter
package dbg_tx_pkg;

    localparam int FRAME_BYTES = 9;
    localparam int BITS_PER_BYTE = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // XOR of the seven debug bytes; the sync byte is deliberately not included
    function automatic logic [7:0] xor_bytes(input logic [55:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 7; i++) begin
            acc = acc ^ bytes[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/dbg_serial_tx_baud_gen.sv
// rtl/dbg_serial_tx_baud_gen.sv - bit-period down-counter with one-cycle bit_end strobe
module baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    // Count down one bit period; held at reload while idle so the first bit of a frame is full length
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (clear || !en || (cnt == 16'd0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign bit_end = en && (cnt == 16'd0);

endmodule

// File: rtl/dbg_serial_tx.sv
// rtl/dbg_serial_tx.sv - captures seven debug bytes and sends them as one 8N1 frame with sync and checksum
module dbg_serial_tx
    import dbg_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       snap,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    tx_state_t   state, state_n;
    logic [7:0]  shift_reg, shift_n;
    logic [71:0] cap, cap_n;
    logic [3:0]  byte_idx, byte_idx_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        txd_n, busy_n, done_n;
    logic        accept;
    logic        bit_end;
    logic [55:0] ports;
    logic [6:0]  byte_base;
    logic [7:0]  cur_byte;

    assign ports     = {debug_port7, debug_port6, debug_port5, debug_port4,
                        debug_port3, debug_port2, debug_port1};
    assign byte_base = {byte_idx, 3'b000};
    assign cur_byte  = cap[byte_base +: 8];

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .en      (busy),
        .bit_end (bit_end)
    );

    // State, datapath and output flops; outputs are registered so nothing combinational reaches the pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= 8'h00;
            cap       <= 72'h0;
            byte_idx  <= 4'd0;
            bit_idx   <= 3'd0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            cap       <= cap_n;
            byte_idx  <= byte_idx_n;
            bit_idx   <= bit_idx_n;
            txd       <= txd_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next state and next output values; the capture holds sync, seven ports and checksum as nine bytes
    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        cap_n      = cap;
        byte_idx_n = byte_idx;
        bit_idx_n  = bit_idx;
        txd_n      = txd;
        busy_n     = busy;
        done_n     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                txd_n  = 1'b1;
                busy_n = 1'b0;
                if (snap) begin
                    accept     = 1'b1;
                    cap_n      = {xor_bytes(ports), ports, SYNC_BYTE};
                    byte_idx_n = 4'd0;
                    bit_idx_n  = 3'd0;
                    txd_n      = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_n     = cur_byte[0];
                    shift_n   = {1'b0, cur_byte[7:1]};
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        txd_n     = shift_reg[0];
                        shift_n   = {1'b0, shift_reg[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx < LAST_BYTE) begin
                        byte_idx_n = byte_idx + 4'd1;
                        txd_n      = 1'b0;
                        state_n    = START;
                    end else begin
                        txd_n   = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
